// File: rtl/regfile_wb_buffer_if.sv
// regfile_wb_buffer_if: writeback request, register file write port, forwarding query and occupancy signals.
interface regfile_wb_buffer_if #(parameter int DEPTH = 4, parameter int DATA_W = 64, parameter int ADDR_W = 5);
  logic                     wb_valid;
  logic [ADDR_W-1:0]        wb_rd;
  logic [DATA_W-1:0]        wb_data;
  logic                     wb_ready;
  logic                     rf_grant;
  logic [ADDR_W-1:0]        rf_rd;
  logic [DATA_W-1:0]        rf_wdata;
  logic                     rf_regwrite;
  logic [ADDR_W-1:0]        q_rs1;
  logic [ADDR_W-1:0]        q_rs2;
  logic                     fwd1_hit;
  logic [DATA_W-1:0]        fwd1_data;
  logic                     fwd2_hit;
  logic [DATA_W-1:0]        fwd2_data;
  logic [$clog2(DEPTH):0]   pending;
  modport master (output wb_valid, wb_rd, wb_data, rf_grant, q_rs1, q_rs2,
                  input wb_ready, rf_rd, rf_wdata, rf_regwrite, fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, pending);
  modport slave (input wb_valid, wb_rd, wb_data, rf_grant, q_rs1, q_rs2,
                 output wb_ready, rf_rd, rf_wdata, rf_regwrite, fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, pending);
endinterface

// File: rtl/regfile_wb_buffer.sv
// regfile_wb_buffer: FIFO of pending register writebacks with youngest-first forwarding lookups.
// Define WB_BUFFER_BYPASS_EN for a zero-latency path from wb_* to rf_* when the queue is empty.
module regfile_wb_buffer #(
  parameter int DEPTH = 4,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input logic clk,
  input logic reset,
  regfile_wb_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [ADDR_W-1:0] rd_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d, idx;
  logic [CW-1:0]     count_q, count_d;
  logic              empty, push, pop, byp;
  logic              f1_hit, f2_hit;
  logic [DATA_W-1:0] f1_data, f2_data;
  assign empty = count_q == '0;
  assign bus.wb_ready = (count_q < CW'(DEPTH)) && !reset;
  assign pop = !empty && bus.rf_grant && !reset;
`ifdef WB_BUFFER_BYPASS_EN
  assign byp = empty && bus.rf_grant && bus.wb_valid && bus.wb_rd != '0 && !reset;
`else
  assign byp = 1'b0;
`endif
  // x0 writes complete the handshake but are dropped here
  assign push = bus.wb_valid && bus.wb_ready && bus.wb_rd != '0 && !byp;
  assign bus.rf_regwrite = pop || byp;
  assign bus.rf_rd = byp ? bus.wb_rd : (!empty && !reset) ? rd_q[head_q] : '0;
  assign bus.rf_wdata = byp ? bus.wb_data : (!empty && !reset) ? data_q[head_q] : '0;
  assign bus.pending = reset ? '0 : count_q;
  assign bus.fwd1_hit = f1_hit;
  assign bus.fwd1_data = f1_data;
  assign bus.fwd2_hit = f2_hit;
  assign bus.fwd2_data = f2_data;
  always_comb begin
    head_d = pop ? head_q + PW'(1) : head_q;
    tail_d = push ? tail_q + PW'(1) : tail_q;
    count_d = count_q + CW'(push) - CW'(pop);
    valid_d = (valid_q & ~(DEPTH'(pop) << head_q)) | (DEPTH'(push) << tail_q);
  end
  // walk oldest to youngest so the youngest match overwrites earlier ones
  always_comb begin
    f1_hit = 1'b0;
    f1_data = '0;
    f2_hit = 1'b0;
    f2_data = '0;
    idx = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (!reset && valid_q[idx] && bus.q_rs1 != '0 && rd_q[idx] == bus.q_rs1) begin
        f1_hit = 1'b1;
        f1_data = data_q[idx];
      end
      if (!reset && valid_q[idx] && bus.q_rs2 != '0 && rd_q[idx] == bus.q_rs2) begin
        f2_hit = 1'b1;
        f2_data = data_q[idx];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[tail_q] <= bus.wb_rd;
      data_q[tail_q] <= bus.wb_data;
    end
  end
endmodule
